// File: rtl/waveform_sequencer_if.sv
// Sample handoff bus between the waveform sequencer and the DAC driver.
interface waveform_sequencer_if #(
   parameter int unsigned DATA_W = 12
);
   logic [DATA_W-1:0] dac_va;
   logic [DATA_W-1:0] dac_vb;
   logic              dac_valid;
   logic              dac_ready;

   modport master (
      output dac_va,
      output dac_vb,
      output dac_valid,
      input  dac_ready
   );

   modport slave (
      input  dac_va,
      input  dac_vb,
      input  dac_valid,
      output dac_ready
   );
endinterface

// File: rtl/waveform_sequencer.sv
// Tick-paced triangle/sawtooth/square/hold generator feeding a two-channel DAC
// driver through a valid/ready handoff. Channel B is always the complement of A.
// Rate and mode are sampled on entry to RUN and at every tick; the mode captured
// at a tick governs the steps taken from the following tick on.
module waveform_sequencer #(
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned BASE_DIV = 1000
) (
   input  logic                 CLK_50M,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [3:0]           SW,
   input  logic [1:0]           mode,
   waveform_sequencer_if.master dac,
   output logic                 direction,
   output logic                 overrun
);
   localparam int unsigned       CNT_W     = 32;
   localparam logic [DATA_W-1:0] MAX       = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
   localparam logic [1:0]        MODE_TRI  = 2'b00;
   localparam logic [1:0]        MODE_SAW  = 2'b01;
   localparam logic [1:0]        MODE_SQR  = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      HANDOFF = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  count, count_d;
   logic [CNT_W-1:0]  period_m1;
   logic [3:0]        sw_l, sw_l_d;
   logic [1:0]        mode_l, mode_l_d;
   logic [DATA_W-1:0] phase, phase_d;
   logic [DATA_W-1:0] va, va_d;
   logic [DATA_W-1:0] vb, vb_d;
   logic              dir_q, dir_d;
   logic              valid, valid_d;
   logic              ovr, ovr_d;
   logic              tick;
   logic [DATA_W-1:0] step_phase;
   logic [DATA_W-1:0] step_va;
   logic              step_dir;

   // Divider terminal count: (SW_l+1)*BASE_DIV - 1, 32 bits so SW=15 cannot overflow.
   assign period_m1 = (CNT_W'(sw_l) + CNT_W'(1)) * CNT_W'(BASE_DIV) - CNT_W'(1);
   assign tick      = (state != IDLE) && (count == period_m1);

   // Phase step for one accepted tick under the latched mode.
   always_comb begin
      step_phase = phase;
      step_dir   = dir_q;
      step_va    = va;
      case (mode_l)
         MODE_TRI, MODE_SQR: begin
            if (dir_q) begin
               step_phase = phase + ONE;
               if (step_phase == MAX) step_dir = 1'b0;
            end else begin
               step_phase = phase - ONE;
               if (step_phase == '0) step_dir = 1'b1;
            end
            // Square level follows the direction in force at the tick, so the
            // first level from phase 0 lasts exactly MAX ticks.
            if (mode_l == MODE_SQR) step_va = dir_q ? MAX : '0;
            else                    step_va = step_phase;
         end
         MODE_SAW: begin
            step_phase = phase + ONE;
            step_dir   = 1'b1;
            step_va    = step_phase;
         end
         default: begin
            step_phase = phase;
            step_dir   = dir_q;
            step_va    = va;
         end
      endcase
   end

   // Next-state, divider, sample and handshake logic.
   always_comb begin
      state_d  = state;
      count_d  = count;
      sw_l_d   = sw_l;
      mode_l_d = mode_l;
      phase_d  = phase;
      dir_d    = dir_q;
      va_d     = va;
      vb_d     = vb;
      valid_d  = valid;
      ovr_d    = 1'b0;

      case (state)
         IDLE: begin
            count_d = '0;
            valid_d = 1'b0;
            if (enable) begin
               state_d  = RUN;
               sw_l_d   = SW;
               mode_l_d = mode;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               count_d = '0;
            end else if (tick) begin
               state_d  = HANDOFF;
               count_d  = '0;
               sw_l_d   = SW;
               mode_l_d = mode;
               phase_d  = step_phase;
               dir_d    = step_dir;
               va_d     = step_va;
               vb_d     = ~step_va;
               valid_d  = 1'b1;
            end else begin
               count_d = count + CNT_W'(1);
            end
         end
         HANDOFF: begin
            if (dac.dac_ready) begin
               if (!enable) begin
                  state_d = IDLE;
                  count_d = '0;
                  valid_d = 1'b0;
               end else if (tick) begin
                  // Handshake and tick together: next sample goes straight out.
                  count_d  = '0;
                  sw_l_d   = SW;
                  mode_l_d = mode;
                  phase_d  = step_phase;
                  dir_d    = step_dir;
                  va_d     = step_va;
                  vb_d     = ~step_va;
                  valid_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  count_d = count + CNT_W'(1);
                  valid_d = 1'b0;
               end
            end else if (tick) begin
               // Driver still busy: drop this tick, keep the pending sample.
               count_d  = '0;
               sw_l_d   = SW;
               mode_l_d = mode;
               ovr_d    = 1'b1;
            end else begin
               count_d = count + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK_50M or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         sw_l   <= '0;
         mode_l <= '0;
         phase  <= '0;
         dir_q  <= 1'b1;
         va     <= '0;
         vb     <= MAX;
         valid  <= 1'b0;
         ovr    <= 1'b0;
      end else begin
         state  <= state_d;
         count  <= count_d;
         sw_l   <= sw_l_d;
         mode_l <= mode_l_d;
         phase  <= phase_d;
         dir_q  <= dir_d;
         va     <= va_d;
         vb     <= vb_d;
         valid  <= valid_d;
         ovr    <= ovr_d;
      end
   end

   assign dac.dac_va    = va;
   assign dac.dac_vb    = vb;
   assign dac.dac_valid = valid;
   assign direction     = dir_q;
   assign overrun       = ovr;
endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed bench for waveform_sequencer with BASE_DIV=4 and 12-bit samples.
module tb_waveform_sequencer;
   localparam int unsigned DATA_W   = 12;
   localparam int unsigned BASE_DIV = 4;
   localparam int          MAXV     = 4095;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [3:0] sw;
   logic [1:0] mode;
   logic       direction;
   logic       overrun;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int last_cyc = 0;
   int gap      = 0;

   waveform_sequencer_if #(.DATA_W(DATA_W)) dac_bus ();

   waveform_sequencer #(.DATA_W(DATA_W), .BASE_DIV(BASE_DIV)) dut (
      .CLK_50M  (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .SW       (sw),
      .mode     (mode),
      .dac      (dac_bus),
      .direction(direction),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Advance to the next negedge showing dac_valid; records spacing in cycles.
   task automatic next_sample(input string tag, input int limit);
      int n;
      n = 0;
      @(negedge clk);
      while (dac_bus.dac_valid !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (dac_bus.dac_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout: no dac_valid within %0d cycles", tag, limit);
      end
      gap      = cyc - last_cyc;
      last_cyc = cyc;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n           = 1'b0;
      enable            = 1'b0;
      sw                = 4'd0;
      mode              = 2'b00;
      dac_bus.dac_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (dac_bus.dac_va !== 12'd0 || dac_bus.dac_vb !== 12'd4095 || dac_bus.dac_valid !== 1'b0 ||
          overrun !== 1'b0 || direction !== 1'b1)
         begin errors++; $display("FAIL reset_values va=%0d vb=%0d valid=%b ovr=%b dir=%b want 0/4095/0/0/1",
                   dac_bus.dac_va, dac_bus.dac_vb, dac_bus.dac_valid, overrun, direction); end
      enable  = 1'b1;
      reset_n = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         checks++;
         if (n < 5) begin
            if (dac_bus.dac_valid !== 1'b0) begin
               errors++; $display("FAIL first_latency n=%0d valid=%b want 0", n, dac_bus.dac_valid);
            end
         end else if (dac_bus.dac_valid !== 1'b1 || dac_bus.dac_va !== 12'd1) begin
            errors++; $display("FAIL first_sample valid=%b va=%0d want 1/1", dac_bus.dac_valid, dac_bus.dac_va);
         end
      end
      last_cyc = cyc;
      for (int i = 2; i <= 100; i++) next_sample("to_100", 8);
      checks++;
      if (dac_bus.dac_va !== 12'd100) begin
         errors++; $display("FAIL reach_100 va=%0d want 100", dac_bus.dac_va);
      end
      dac_bus.dac_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (dac_bus.dac_va !== 12'd0 || dac_bus.dac_vb !== 12'd4095 || dac_bus.dac_valid !== 1'b0 ||
          overrun !== 1'b0 || direction !== 1'b1)
         begin errors++; $display("FAIL async_reset va=%0d vb=%0d valid=%b ovr=%b dir=%b want 0/4095/0/0/1",
                   dac_bus.dac_va, dac_bus.dac_vb, dac_bus.dac_valid, overrun, direction); end
      @(negedge clk);
      reset_n           = 1'b1;
      dac_bus.dac_ready = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         checks++;
         if (n < 5) begin
            if (dac_bus.dac_valid !== 1'b0) begin
               errors++; $display("FAIL post_reset_latency n=%0d valid=%b want 0", n, dac_bus.dac_valid);
            end
         end else if (dac_bus.dac_valid !== 1'b1 || dac_bus.dac_va !== 12'd1) begin
            errors++; $display("FAIL post_reset_sample valid=%b va=%0d want 1/1", dac_bus.dac_valid, dac_bus.dac_va);
         end
      end
   endtask

   task automatic test_triangle();
      int   exp_v;
      logic exp_d;
      mode   = 2'b00;
      sw     = 4'd0;
      enable = 1'b1;
      dac_bus.dac_ready = 1'b1;
      pulse_reset();
      last_cyc = cyc;
      for (int i = 1; i <= 8191; i++) begin
         next_sample("tri", 8);
         if (i <= 4095)      exp_v = i;
         else if (i <= 8190) exp_v = 8190 - i;
         else                exp_v = i - 8190;
         exp_d = (i >= 4095 && i < 8190) ? 1'b0 : 1'b1;
         checks++;
         if (dac_bus.dac_va !== 12'(exp_v)) begin
            errors++; $display("FAIL tri_va i=%0d got %0d want %0d", i, dac_bus.dac_va, exp_v);
         end
         checks++;
         if (dac_bus.dac_vb !== 12'(MAXV - exp_v)) begin
            errors++; $display("FAIL tri_vb i=%0d got %0d want %0d", i, dac_bus.dac_vb, MAXV - exp_v);
         end
         checks++;
         if (direction !== exp_d) begin
            errors++; $display("FAIL tri_dir i=%0d got %b want %b", i, direction, exp_d);
         end
         if (i > 1) begin
            checks++;
            if (gap !== 4) begin
               errors++; $display("FAIL tri_period i=%0d got %0d want 4", i, gap);
            end
         end
      end
   endtask

   task automatic test_sawtooth();
      int exp_v;
      for (int j = 2; j <= 4088; j++) next_sample("climb", 8);
      checks++;
      if (dac_bus.dac_va !== 12'd4088) begin
         errors++; $display("FAIL climb_va got %0d want 4088", dac_bus.dac_va);
      end
      mode = 2'b01;
      sw   = 4'd3;
      for (int k = 1; k <= 9; k++) begin
         next_sample("saw", 20);
         exp_v = (4088 + k) % 4096;
         checks++;
         if (dac_bus.dac_va !== 12'(exp_v) || dac_bus.dac_vb !== 12'(MAXV - exp_v)) begin
            errors++; $display("FAIL saw_va k=%0d got %0d/%0d want %0d/%0d", k,
                               dac_bus.dac_va, dac_bus.dac_vb, exp_v, MAXV - exp_v);
         end
         checks++;
         if (direction !== 1'b1) begin
            errors++; $display("FAIL saw_dir k=%0d got %b want 1", k, direction);
         end
         checks++;
         if (gap !== ((k == 1) ? 4 : 16)) begin
            errors++; $display("FAIL saw_period k=%0d got %0d want %0d", k, gap, (k == 1) ? 4 : 16);
         end
      end
   endtask

   task automatic test_square_hold();
      int exp_v;
      int exp_tab [12] = '{0, 4073, 4072, 4071, 4071, 4071, 4071, 4071, 4071, 4071, 4070, 4069};
      mode   = 2'b10;
      sw     = 4'd0;
      enable = 1'b1;
      dac_bus.dac_ready = 1'b1;
      pulse_reset();
      last_cyc = cyc;
      for (int i = 1; i <= 4115; i++) begin
         next_sample("sqr", 8);
         exp_v = (i <= 4095) ? MAXV : 0;
         checks++;
         if (dac_bus.dac_va !== 12'(exp_v) || dac_bus.dac_vb !== 12'(MAXV - exp_v)) begin
            errors++; $display("FAIL sqr_va i=%0d got %0d/%0d want %0d/%0d", i,
                               dac_bus.dac_va, dac_bus.dac_vb, exp_v, MAXV - exp_v);
         end
      end
      for (int k = 0; k < 12; k++) begin
         if (k == 0) mode = 2'b00;
         if (k == 3) mode = 2'b11;
         if (k == 9) mode = 2'b00;
         next_sample("hold", 8);
         checks++;
         if (dac_bus.dac_va !== 12'(exp_tab[k]) || direction !== 1'b0 || gap !== 4) begin
            errors++; $display("FAIL hold_seq k=%0d va=%0d dir=%b gap=%0d want %0d/0/4", k,
                               dac_bus.dac_va, direction, gap, exp_tab[k]);
         end
      end
   endtask

   task automatic test_stall();
      int ovr_cnt;
      next_sample("stall_pre", 8);
      checks++;
      if (dac_bus.dac_va !== 12'd4068) begin
         errors++; $display("FAIL stall_pre va=%0d want 4068", dac_bus.dac_va);
      end
      dac_bus.dac_ready = 1'b0;
      ovr_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (overrun === 1'b1) ovr_cnt++;
         checks++;
         if (dac_bus.dac_valid !== 1'b1 || dac_bus.dac_va !== 12'd4068 || dac_bus.dac_vb !== 12'd27) begin
            errors++; $display("FAIL stall_hold c=%0d valid=%b va=%0d vb=%0d want 1/4068/27", c,
                               dac_bus.dac_valid, dac_bus.dac_va, dac_bus.dac_vb);
         end
      end
      dac_bus.dac_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (dac_bus.dac_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL stall_release valid=%b ovr=%b want 0/0", dac_bus.dac_valid, overrun);
      end
      checks++;
      if (ovr_cnt !== 3) begin
         errors++; $display("FAIL overrun_count got %0d want 3", ovr_cnt);
      end
      next_sample("stall_post", 8);
      checks++;
      if (dac_bus.dac_va !== 12'd4067) begin
         errors++; $display("FAIL stall_post va=%0d want 4067", dac_bus.dac_va);
      end
   endtask

   task automatic test_back_to_back();
      next_sample("b2b_pre", 8);
      checks++;
      if (dac_bus.dac_va !== 12'd4066) begin
         errors++; $display("FAIL b2b_pre va=%0d want 4066", dac_bus.dac_va);
      end
      dac_bus.dac_ready = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (dac_bus.dac_valid !== 1'b1 || dac_bus.dac_va !== 12'd4066) begin
            errors++; $display("FAIL b2b_wait c=%0d valid=%b va=%0d want 1/4066", c,
                               dac_bus.dac_valid, dac_bus.dac_va);
         end
      end
      dac_bus.dac_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (dac_bus.dac_valid !== 1'b1 || dac_bus.dac_va !== 12'd4065 || overrun !== 1'b0) begin
         errors++; $display("FAIL b2b_coincide valid=%b va=%0d ovr=%b want 1/4065/0",
                            dac_bus.dac_valid, dac_bus.dac_va, overrun);
      end
      @(negedge clk);
      checks++;
      if (dac_bus.dac_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_done valid=%b want 0", dac_bus.dac_valid);
      end
   endtask

   task automatic test_enable();
      next_sample("en_pre", 8);
      checks++;
      if (dac_bus.dac_va !== 12'd4064) begin
         errors++; $display("FAIL en_pre va=%0d want 4064", dac_bus.dac_va);
      end
      dac_bus.dac_ready = 1'b0;
      enable            = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         checks++;
         if (dac_bus.dac_valid !== 1'b1 || dac_bus.dac_va !== 12'd4064) begin
            errors++; $display("FAIL en_pending c=%0d valid=%b va=%0d want 1/4064", c,
                               dac_bus.dac_valid, dac_bus.dac_va);
         end
      end
      dac_bus.dac_ready = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         checks++;
         if (dac_bus.dac_valid !== 1'b0 || dac_bus.dac_va !== 12'd4064 || direction !== 1'b0) begin
            errors++; $display("FAIL en_idle c=%0d valid=%b va=%0d dir=%b want 0/4064/0", c,
                               dac_bus.dac_valid, dac_bus.dac_va, direction);
         end
      end
      enable = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         checks++;
         if (n < 5) begin
            if (dac_bus.dac_valid !== 1'b0) begin
               errors++; $display("FAIL reen_latency n=%0d valid=%b want 0", n, dac_bus.dac_valid);
            end
         end else if (dac_bus.dac_valid !== 1'b1 || dac_bus.dac_va !== 12'd4063) begin
            errors++; $display("FAIL reen_sample valid=%b va=%0d want 1/4063", dac_bus.dac_valid, dac_bus.dac_va);
         end
      end
      @(negedge clk);
      enable = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (dac_bus.dac_valid !== 1'b0 || dac_bus.dac_va !== 12'd4063) begin
            errors++; $display("FAIL run_drop c=%0d valid=%b va=%0d want 0/4063", c,
                               dac_bus.dac_valid, dac_bus.dac_va);
         end
      end
      enable = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         checks++;
         if (n < 5) begin
            if (dac_bus.dac_valid !== 1'b0) begin
               errors++; $display("FAIL run_reen_latency n=%0d valid=%b want 0", n, dac_bus.dac_valid);
            end
         end else if (dac_bus.dac_valid !== 1'b1 || dac_bus.dac_va !== 12'd4062) begin
            errors++; $display("FAIL run_reen_sample valid=%b va=%0d want 1/4062", dac_bus.dac_valid, dac_bus.dac_va);
         end
      end
   endtask

   initial begin
      test_reset();
      test_triangle();
      test_sawtooth();
      test_square_hold();
      test_stall();
      test_back_to_back();
      test_enable();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
